// File: rtl/bit_route_pkg.sv
// Shared types for the bit-level router: FSM states, map entry layout, index width helper.
package bit_route_pkg;

  // Widest source select a map entry can hold (up to 16 source bits).
  localparam int unsigned MAP_SEL_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    COPY,
    SETTLE,
    ACK,
    WAIT_DROP
  } state_e;

  typedef struct packed {
    logic                 en;
    logic [MAP_SEL_W-1:0] sel;
  } map_entry_t;

  // Index width for an n-entry vector, never below 1.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bit_route_if.sv
// Host config, commit handshake and data buses of the bit router.
interface bit_route_if #(
  parameter int unsigned SRC_WIDTH  = 4,
  parameter int unsigned SINK_WIDTH = 4
);
  localparam int unsigned SRC_IDX_W  = bit_route_pkg::idx_w(SRC_WIDTH);
  localparam int unsigned SINK_IDX_W = bit_route_pkg::idx_w(SINK_WIDTH);

  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [SINK_IDX_W-1:0] cfg_sink_idx;
  logic [SRC_IDX_W-1:0]  cfg_src_idx;
  logic                  cfg_en;
  logic                  cfg_err;
  logic                  commit_req;
  logic                  commit_ack;
  logic                  busy;
  logic [SRC_WIDTH-1:0]  source_bus;
  logic [SINK_WIDTH-1:0] sink_bus;
  logic [SINK_WIDTH-1:0] active_en;

  modport master (
    output cfg_valid, cfg_sink_idx, cfg_src_idx, cfg_en, commit_req, source_bus,
    input  cfg_ready, cfg_err, commit_ack, busy, sink_bus, active_en
  );

  modport slave (
    input  cfg_valid, cfg_sink_idx, cfg_src_idx, cfg_en, commit_req, source_bus,
    output cfg_ready, cfg_err, commit_ack, busy, sink_bus, active_en
  );
endinterface

// File: rtl/bit_route_table.sv
// Shadow/active routing maps and the registered sink mux.
module bit_route_table
  import bit_route_pkg::*;
#(
  parameter int unsigned SRC_WIDTH  = 4,
  parameter int unsigned SINK_WIDTH = 4,
  parameter int unsigned SRC_IDX_W  = 2,
  parameter int unsigned SINK_IDX_W = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [SINK_IDX_W-1:0] wr_idx,
  input  logic [SRC_IDX_W-1:0]  wr_sel,
  input  logic                  wr_conn,
  input  logic                  copy,
  input  logic [SRC_WIDTH-1:0]  source_bus,
  output logic [SINK_WIDTH-1:0] sink_bus,
  output logic [SINK_WIDTH-1:0] active_en
);

  map_entry_t            shadow_q [SINK_WIDTH];
  map_entry_t            shadow_d [SINK_WIDTH];
  map_entry_t            active_q [SINK_WIDTH];
  map_entry_t            active_d [SINK_WIDTH];
  logic [SINK_WIDTH-1:0] sink_q;
  logic [SINK_WIDTH-1:0] sink_d;

  // Shadow write decode, whole-map copy, and routing of each sink bit from the active map.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    sink_d   = '0;
    for (int unsigned i = 0; i < SINK_WIDTH; i++) begin
      if (wr_en && (32'(wr_idx) == i)) begin
        shadow_d[i].en  = wr_conn;
        shadow_d[i].sel = MAP_SEL_W'(wr_sel);
      end
    end
    if (copy) begin
      active_d = shadow_q;
    end
    for (int unsigned i = 0; i < SINK_WIDTH; i++) begin
      for (int unsigned j = 0; j < SRC_WIDTH; j++) begin
        if (active_q[i].en && (active_q[i].sel == MAP_SEL_W'(j))) begin
          sink_d[i] = source_bus[j];
        end
      end
    end
  end

  // Map and sink registers; reset leaves every sink bit disconnected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '{default: '0};
      active_q <= '{default: '0};
      sink_q   <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      sink_q   <= sink_d;
    end
  end

  // Connect flags of the active map, straight from its registers.
  always_comb begin
    for (int unsigned i = 0; i < SINK_WIDTH; i++) begin
      active_en[i] = active_q[i].en;
    end
  end

  assign sink_bus = sink_q;

endmodule

// File: rtl/bit_route_ctrl.sv
// Bit router top: commit FSM, config handshake, index range check.
module bit_route_ctrl
  import bit_route_pkg::*;
#(
  parameter int unsigned SRC_WIDTH  = 4,
  parameter int unsigned SINK_WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  bit_route_if.slave  bus
);

  localparam int unsigned SRC_IDX_W  = idx_w(SRC_WIDTH);
  localparam int unsigned SINK_IDX_W = idx_w(SINK_WIDTH);

  state_e state_q, state_d;
  logic   cfg_ready_q, cfg_ready_d;
  logic   cfg_err_q, cfg_err_d;
  logic   commit_ack_q, commit_ack_d;
  logic   busy_q, busy_d;
  logic   cfg_fire_c, idx_oor_c, wr_ok_c, copy_c;

  // Next state, write acceptance and next values of the registered status outputs.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (bus.commit_req) state_d = COPY;
      COPY:      state_d = SETTLE;
      SETTLE:    state_d = ACK;
      ACK:       state_d = bus.commit_req ? WAIT_DROP : IDLE;
      WAIT_DROP: if (!bus.commit_req) state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    // Ready is the registered view of IDLE, so acceptance matches what the host sees.
    cfg_fire_c = bus.cfg_valid & cfg_ready_q;
    idx_oor_c  = (32'(bus.cfg_sink_idx) >= SINK_WIDTH) || (32'(bus.cfg_src_idx) >= SRC_WIDTH);
    wr_ok_c    = cfg_fire_c & ~idx_oor_c;
    copy_c     = (state_q == COPY);

    cfg_ready_d  = (state_d == IDLE);
    busy_d       = (state_d != IDLE);
    commit_ack_d = (state_d == ACK);
    cfg_err_d    = cfg_fire_c & idx_oor_c;
  end

  // FSM and status output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cfg_ready_q  <= 1'b0;
      cfg_err_q    <= 1'b0;
      commit_ack_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cfg_ready_q  <= cfg_ready_d;
      cfg_err_q    <= cfg_err_d;
      commit_ack_q <= commit_ack_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.cfg_ready  = cfg_ready_q;
  assign bus.cfg_err    = cfg_err_q;
  assign bus.commit_ack = commit_ack_q;
  assign bus.busy       = busy_q;

  bit_route_table #(
    .SRC_WIDTH  (SRC_WIDTH),
    .SINK_WIDTH (SINK_WIDTH),
    .SRC_IDX_W  (SRC_IDX_W),
    .SINK_IDX_W (SINK_IDX_W)
  ) u_table (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_ok_c),
    .wr_idx     (bus.cfg_sink_idx),
    .wr_sel     (bus.cfg_src_idx),
    .wr_conn    (bus.cfg_en),
    .copy       (copy_c),
    .source_bus (bus.source_bus),
    .sink_bus   (bus.sink_bus),
    .active_en  (bus.active_en)
  );

endmodule

// File: tb/tb_bit_route_ctrl.sv
// Scoreboard bench for bit_route_ctrl: 4x4 main instance plus a 3x3 instance for range errors.
module tb_bit_route_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bit_route_if #(.SRC_WIDTH(4), .SINK_WIDTH(4)) bus  ();
  bit_route_if #(.SRC_WIDTH(3), .SINK_WIDTH(3)) bus3 ();

  bit_route_ctrl #(.SRC_WIDTH(4), .SINK_WIDTH(4)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  bit_route_ctrl #(.SRC_WIDTH(3), .SINK_WIDTH(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  int n_total = 0;
  int n_bad   = 0;

  logic [3:0] exp_q[$];
  logic       m_sh_en [4];
  logic [1:0] m_sh_sel[4];
  logic       m_ac_en [4];
  logic [1:0] m_ac_sel[4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] route(input logic [3:0] s);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) if (m_ac_en[i]) r[i] = s[m_ac_sel[i]];
    return r;
  endfunction

  function automatic logic [3:0] en_vec();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = m_ac_en[i];
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_sh_en[i] = 1'b0; m_sh_sel[i] = 2'd0; m_ac_en[i] = 1'b0; m_ac_sel[i] = 2'd0;
    end
  endtask

  // Push the expected routed value, drive the source, pop and compare one cycle later.
  task automatic drive_src(input string tag, input logic [3:0] v);
    logic [3:0] e;
    exp_q.push_back(route(v));
    bus.source_bus = v;
    tick();
    e = exp_q.pop_front();
    check(tag, 32'(bus.sink_bus), 32'(e));
  endtask

  task automatic cfg_write(input int sink, input int src, input logic en);
    check("cfg_ready_pre_wr", 32'(bus.cfg_ready), 32'd1);
    bus.cfg_valid = 1'b1; bus.cfg_sink_idx = 2'(sink); bus.cfg_src_idx = 2'(src); bus.cfg_en = en;
    tick();
    bus.cfg_valid = 1'b0;
    m_sh_en[sink] = en; m_sh_sel[sink] = 2'(src);
    check("cfg_err_inrange", 32'(bus.cfg_err), 32'd0);
  endtask

  // Commit on the main instance; optionally a config write rides the same cycle as the request.
  task automatic commit(input string tag, input bit with_wr, input int sink, input int src, input logic en);
    int n;
    bit got;
    n = 0; got = 0;
    bus.commit_req = 1'b1;
    if (with_wr) begin
      bus.cfg_valid = 1'b1; bus.cfg_sink_idx = 2'(sink); bus.cfg_src_idx = 2'(src); bus.cfg_en = en;
      m_sh_en[sink] = en; m_sh_sel[sink] = 2'(src);
    end
    while (n < 10 && !got) begin
      tick();
      bus.cfg_valid = 1'b0;
      n++;
      if (bus.commit_ack === 1'b1) got = 1;
    end
    check({tag, "_ack_lat"}, 32'(n), 32'd3);
    for (int i = 0; i < 4; i++) begin
      m_ac_en[i] = m_sh_en[i]; m_ac_sel[i] = m_sh_sel[i];
    end
    check({tag, "_active_en"}, 32'(bus.active_en), 32'(en_vec()));
    bus.commit_req = 1'b0;
    tick();
    check({tag, "_ack_drop"}, 32'(bus.commit_ack), 32'd0);
    check({tag, "_busy_drop"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic commit3(input string tag, input logic [2:0] exp_en);
    int n;
    bit got;
    n = 0; got = 0;
    bus3.commit_req = 1'b1;
    while (n < 10 && !got) begin
      tick();
      n++;
      if (bus3.commit_ack === 1'b1) got = 1;
    end
    check({tag, "_ack_lat"}, 32'(n), 32'd3);
    check({tag, "_active_en"}, 32'(bus3.active_en), 32'(exp_en));
    bus3.commit_req = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acks;
    model_clear();
    rst_n = 1'b0;
    bus.cfg_valid = 1'b0; bus.cfg_sink_idx = '0; bus.cfg_src_idx = '0; bus.cfg_en = 1'b0;
    bus.commit_req = 1'b0; bus.source_bus = 4'hF;
    bus3.cfg_valid = 1'b0; bus3.cfg_sink_idx = '0; bus3.cfg_src_idx = '0; bus3.cfg_en = 1'b0;
    bus3.commit_req = 1'b0; bus3.source_bus = '0;

    // Reset state
    repeat (3) tick();
    check("rst_sink", 32'(bus.sink_bus), 32'h0);
    check("rst_active_en", 32'(bus.active_en), 32'h0);
    check("rst_ready", 32'(bus.cfg_ready), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_err", 32'(bus.cfg_err), 32'd0);
    check("rst_ack", 32'(bus.commit_ack), 32'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", 32'(bus.cfg_ready), 32'd1);
    drive_src("rst_route_F", 4'hF);

    // Non-contiguous map; sink2 is written twice and the second write wins
    cfg_write(3, 3, 1'b1);
    cfg_write(2, 0, 1'b1);
    cfg_write(2, 1, 1'b1);
    commit("nc", 1'b0, 0, 0, 1'b0);
    check("nc_en_1100", 32'(bus.active_en), 32'hC);
    drive_src("nc_1010", 4'b1010);
    drive_src("nc_0101", 4'b0101);
    drive_src("nc_1000", 4'b1000);

    // Atomicity: a staged write does not reach the sink until committed
    cfg_write(0, 2, 1'b1);
    drive_src("atom_pre", 4'h4);
    check("atom_pre_0", 32'(bus.sink_bus), 32'h0);
    commit("atom", 1'b0, 0, 0, 1'b0);
    drive_src("atom_post", 4'h4);
    check("atom_post_1", 32'(bus.sink_bus), 32'h1);

    // Fan-out of one source bit, then an unchanged re-commit
    cfg_write(1, 2, 1'b1);
    commit("fan", 1'b0, 0, 0, 1'b0);
    drive_src("fan_4", 4'h4);
    commit("same", 1'b0, 0, 0, 1'b0);
    drive_src("same_4", 4'h4);
    drive_src("same_E", 4'hE);

    // Held request: one ack, busy and not ready until the request drops
    acks = 0;
    bus.commit_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.commit_ack === 1'b1) acks++;
      check("hold_busy", 32'(bus.busy), 32'd1);
      check("hold_ready", 32'(bus.cfg_ready), 32'd0);
    end
    check("hold_acks", 32'(acks), 32'd1);
    bus.commit_req = 1'b0;
    tick();
    check("hold_busy_drop", 32'(bus.busy), 32'd0);
    check("hold_ready_back", 32'(bus.cfg_ready), 32'd1);

    // Write in the same cycle as the request is part of the commit (sink3 disconnect)
    commit("samecyc", 1'b1, 3, 0, 1'b0);
    drive_src("samecyc_F", 4'hF);

    // Reset during SETTLE clears the active map
    bus.commit_req = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_sink", 32'(bus.sink_bus), 32'h0);
    check("midrst_active", 32'(bus.active_en), 32'h0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    model_clear();
    bus.commit_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("midrst_ready", 32'(bus.cfg_ready), 32'd1);
    check("midrst_idle", 32'(bus.busy), 32'd0);
    drive_src("midrst_F", 4'hF);

    // Range errors on the 3x3 instance
    bus3.cfg_valid = 1'b1; bus3.cfg_sink_idx = 2'd0; bus3.cfg_src_idx = 2'd2; bus3.cfg_en = 1'b1;
    tick();
    bus3.cfg_valid = 1'b0;
    check("e3_ok_err", 32'(bus3.cfg_err), 32'd0);
    commit3("e3_first", 3'b001);
    bus3.source_bus = 3'b100;
    tick();
    check("e3_route", 32'(bus3.sink_bus), 32'h1);
    begin
      logic [2:0] seven;
      seven = 3'd7;
      bus3.cfg_valid = 1'b1; bus3.cfg_sink_idx = 2'd1; bus3.cfg_src_idx = seven[1:0]; bus3.cfg_en = 1'b1;
    end
    tick();
    bus3.cfg_valid = 1'b0;
    check("e3_src_err", 32'(bus3.cfg_err), 32'd1);
    tick();
    check("e3_src_err_clr", 32'(bus3.cfg_err), 32'd0);
    bus3.cfg_valid = 1'b1; bus3.cfg_sink_idx = 2'd3; bus3.cfg_src_idx = 2'd0; bus3.cfg_en = 1'b1;
    tick();
    bus3.cfg_valid = 1'b0;
    check("e3_sink_err", 32'(bus3.cfg_err), 32'd1);
    tick();
    check("e3_sink_err_clr", 32'(bus3.cfg_err), 32'd0);
    commit3("e3_after", 3'b001);
    check("e3_route_after", 32'(bus3.sink_bus), 32'h1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
